// File: rtl/flappy_bird_control_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the sysid slave.
interface flappy_bird_control_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/flappy_bird_control_sysid_checker.sv
// Reads system ID (word 0) and build timestamp (word 1) from the sysid slave and
// compares them to the expected pairing; reports match, mismatch or timeout.
module flappy_bird_control_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1449425821,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       start,
  flappy_bird_control_sysid_checker_if.master        avm,
  output logic [31:0]                                id_value,
  output logic [31:0]                                timestamp_value,
  output logic                                       id_match,
  output logic                                       ts_match,
  output logic                                       timeout,
  output logic                                       valid,
  output logic                                       busy,
  output logic                                       done
);

  localparam logic [15:0] WAIT_LAST = TIMEOUT_CYCLES - 16'd1;

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    FINISH
  } state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic        auto_pend;
  logic        rd_q;
  logic        addr_q;

  assign avm.avm_read    = rd_q;
  assign avm.avm_address = addr_q;

  // Control FSM; every output is registered so the bus strobes are glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      wait_cnt        <= 16'd0;
      auto_pend       <= AUTO_START;
      rd_q            <= 1'b0;
      addr_q          <= 1'b0;
      id_value        <= 32'd0;
      timestamp_value <= 32'd0;
      id_match        <= 1'b0;
      ts_match        <= 1'b0;
      timeout         <= 1'b0;
      valid           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          auto_pend <= 1'b0;
          if (start || auto_pend) begin
            state    <= RD_ID;
            rd_q     <= 1'b1;
            addr_q   <= 1'b0;
            busy     <= 1'b1;
            wait_cnt <= 16'd0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            timeout  <= 1'b0;
            valid    <= 1'b0;
          end
        end

        RD_ID: begin
          if (!avm.avm_waitrequest) begin
            id_value <= avm.avm_readdata;
            id_match <= (avm.avm_readdata == EXPECTED_ID);
            state    <= RD_TS;
            addr_q   <= 1'b1;
            wait_cnt <= 16'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout <= 1'b1;
            state   <= FINISH;
            rd_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        RD_TS: begin
          if (!avm.avm_waitrequest) begin
            timestamp_value <= avm.avm_readdata;
            ts_match        <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
            valid           <= 1'b1;
            state           <= FINISH;
            rd_q            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout <= 1'b1;
            state   <= FINISH;
            rd_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        FINISH: begin
          state  <= IDLE;
          addr_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flappy_bird_control_sysid_checker.sv
// Scoreboard bench for the sysid checker: stimulus pushes expected results, a
// monitor pops and compares on every done pulse.
module tb_flappy_bird_control_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1449425821;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;
  logic        id_match;
  logic        ts_match;
  logic        timeout;
  logic        valid;
  logic        busy;
  logic        done;

  flappy_bird_control_sysid_checker_if bus ();

  flappy_bird_control_sysid_checker #(
    .EXPECTED_ID        (32'd0),
    .EXPECTED_TIMESTAMP (TS_GOOD),
    .TIMEOUT_CYCLES     (16'd4),
    .AUTO_START         (1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm             (bus),
    .id_value        (id_value),
    .timestamp_value (timestamp_value),
    .id_match        (id_match),
    .ts_match        (ts_match),
    .timeout         (timeout),
    .valid           (valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Sysid slave model: stalls stall_n cycles per read, or forever when stuck.
  int          stall_n   = 0;
  int          stall_cnt = 0;
  logic        stuck     = 1'b0;
  logic [31:0] id_word   = 32'd0;
  logic [31:0] ts_word   = TS_GOOD;

  assign bus.avm_waitrequest = bus.avm_read && (stuck || (stall_cnt < stall_n));
  assign bus.avm_readdata    = bus.avm_address ? ts_word : id_word;

  always @(posedge clock) begin
    if (reset || !bus.avm_read || !bus.avm_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  typedef struct {
    int          done_cyc;
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        idm;
    logic        tsm;
    logic        to;
    logic        v;
    int          reads;
    int          reads1;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dc, input logic [31:0] idv, input logic [31:0] tsv,
                      input logic idm, input logic tsm, input logic to, input logic v,
                      input int r, input int r1);
    exp_t e;
    e.done_cyc = dc;  e.idv = idv;  e.tsv = tsv;
    e.idm = idm;  e.tsm = tsm;  e.to = to;  e.v = v;
    e.reads = r;  e.reads1 = r1;
    sb_q.push_back(e);
  endtask

  // Monitor: counts bus reads per check and scores each done pulse.
  int rd_cnt  = 0;
  int rd1_cnt = 0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      rd_cnt  = 0;
      rd1_cnt = 0;
    end else begin
      if (bus.avm_read) begin
        rd_cnt++;
        if (bus.avm_address) rd1_cnt++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 with no check pending (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle",      32'(cyc),           32'(e.done_cyc));
          chk("id_value",        id_value,           e.idv);
          chk("timestamp_value", timestamp_value,    e.tsv);
          chk("id_match",        32'(id_match),      32'(e.idm));
          chk("ts_match",        32'(ts_match),      32'(e.tsm));
          chk("timeout",         32'(timeout),       32'(e.to));
          chk("valid",           32'(valid),         32'(e.v));
          chk("busy_at_done",    32'(busy),          32'd0);
          chk("read_cycles",     32'(rd_cnt),        32'(e.reads));
          chk("addr1_cycles",    32'(rd1_cnt),       32'(e.reads1));
        end
        rd_cnt  = 0;
        rd1_cnt = 0;
      end
    end
  end

  task automatic drain();
    int b = 0;
    while (sb_q.size() != 0 && b < 60) begin
      @(negedge clock);
      b++;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d checks still pending after %0d cycles", sb_q.size(), b);
      sb_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_id_value"},  id_value,                 32'd0);
    chk({tag, "_ts_value"},  timestamp_value,          32'd0);
    chk({tag, "_id_match"},  32'(id_match),            32'd0);
    chk({tag, "_ts_match"},  32'(ts_match),            32'd0);
    chk({tag, "_timeout"},   32'(timeout),             32'd0);
    chk({tag, "_valid"},     32'(valid),               32'd0);
    chk({tag, "_busy"},      32'(busy),                32'd0);
    chk({tag, "_done"},      32'(done),                32'd0);
    chk({tag, "_avm_read"},  32'(bus.avm_read),        32'd0);
    chk({tag, "_avm_addr"},  32'(bus.avm_address),     32'd0);
  endtask

  // Start pulse in cycle c; expected done cycle is c + latency.
  task automatic launch(input int lat, input logic [31:0] idv, input logic [31:0] tsv,
                        input logic idm, input logic tsm, input logic to, input logic v,
                        input int r, input int r1);
    @(negedge clock);
    start = 1'b1;
    push(cyc + lat, idv, tsv, idm, tsm, to, v, r, r1);
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int c;

    // Reset state, then automatic check after release.
    repeat (3) @(negedge clock);
    check_reset_outputs("rst_init");
    @(negedge clock);
    reset = 1'b0;
    push(cyc + 3, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1);
    @(posedge clock);
    #1;
    chk("auto_read_after_init",  32'(bus.avm_read),    32'd1);
    chk("auto_addr_after_init",  32'(bus.avm_address), 32'd0);
    drain();

    // Zero-wait, matching pair.
    launch(3, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1);
    drain();

    // ID mismatch.
    id_word = 32'h0000_0005;
    launch(3, 32'd5, TS_GOOD, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1);
    drain();

    // Three stall cycles on each read.
    id_word = 32'd0;
    stall_n = 3;
    launch(9, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 1'b1, 8, 4);
    drain();

    // Stuck slave: abort in RD_ID, previous values held.
    stuck = 1'b1;
    launch(5, 32'd0, TS_GOOD, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0);
    drain();
    stuck = 1'b0;

    // Reset asserted while RD_TS is stalling.
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("in_rd_ts_addr", 32'(bus.avm_address), 32'd1);
    chk("in_rd_ts_read", 32'(bus.avm_read),    32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    stall_n = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    push(cyc + 3, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1);
    @(posedge clock);
    #1;
    chk("auto_read_after_mid",  32'(bus.avm_read),    32'd1);
    chk("auto_addr_after_mid",  32'(bus.avm_address), 32'd0);
    drain();

    // start held through RD_ID, RD_TS, FINISH: exactly two back-to-back checks.
    @(negedge clock);
    start = 1'b1;
    c = cyc;
    push(c + 3, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1);
    push(c + 7, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1);
    repeat (8) @(negedge clock);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clock);
    chk("idle_after_held_start", 32'(busy),         32'd0);
    chk("no_read_after_held",    32'(bus.avm_read), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
